// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: safety stage between the 4-way light controller
// and the physical lamps. Legal codes pass through one register stage; any
// invalid, conflicting, mis-sequenced, short-yellow or stalled input latches a
// fault and forces flashing red until fault_clear.
// Optional feature macro: TRAFFIC_MONITOR_FAULT_COUNT_EN adds fault_count[7:0].
module traffic_conflict_monitor #(
  parameter int YELLOW_MIN   = 10,
  parameter int STARTUP_HOLD = 4,
  parameter int FLASH_HALF   = 25,
  parameter int WATCHDOG_MAX = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ns_light_in,
  input  logic [2:0] ew_light_in,
  input  logic       fault_clear,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash
`ifdef TRAFFIC_MONITOR_FAULT_COUNT_EN
  ,
  output logic [7:0] fault_count
`endif
);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] DARK   = 3'b000;

  localparam int YW = $clog2(YELLOW_MIN + 1);
  localparam int WW = $clog2(WATCHDOG_MAX + 1);
  localparam int SW = $clog2(STARTUP_HOLD + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);

  typedef enum logic [1:0] {ST_STARTUP, ST_PASS, ST_FAULT} state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   start_cnt_reg, start_cnt_next;
  logic [FW-1:0]   flash_cnt_reg, flash_cnt_next;
  logic            flash_reg, flash_next;
  logic [2:0]      code_reg, code_next;
  logic [2:0]      ns_lamp_reg, ns_lamp_next;
  logic [2:0]      ew_lamp_reg, ew_lamp_next;
  logic [2:0]      prev_ns_reg, prev_ew_reg;
  logic [WW-1:0]   wd_reg, wd_next;

  logic [1:0][2:0] light_in;
  logic [1:0][2:0] light_prev;
  logic [1:0]      bad_code, non_red, bad_step, short_yellow;
  logic            counter_clear;
  logic            in_same;
  logic [2:0]      detect_code;

  assign light_in      = {ew_light_in, ns_light_in};
  assign light_prev    = {prev_ew_reg, prev_ns_reg};
  assign counter_clear = (state_reg == ST_FAULT) && fault_clear;
  assign in_same       = (ns_light_in == prev_ns_reg) && (ew_light_in == prev_ew_reg);

  // Per-approach code checks and yellow run counters (index 0 = NS, 1 = EW)
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_approach
      logic [YW-1:0] ycnt_reg;

      assign bad_code[gi] = !((light_in[gi] == RED) || (light_in[gi] == YELLOW) ||
                              (light_in[gi] == GREEN));
      assign non_red[gi]  = (light_in[gi] != RED);
      assign bad_step[gi] = ((light_prev[gi] == GREEN)  && (light_in[gi] == RED))    ||
                            ((light_prev[gi] == YELLOW) && (light_in[gi] == GREEN))  ||
                            ((light_prev[gi] == RED)    && (light_in[gi] == YELLOW));
      assign short_yellow[gi] = (light_prev[gi] == YELLOW) && (light_in[gi] == RED) &&
                                (ycnt_reg < YW'(YELLOW_MIN));

      // Consecutive-yellow counter, saturating at YELLOW_MIN
      always_ff @(posedge clk) begin
        if (reset || counter_clear) begin
          ycnt_reg <= '0;
        end else if (light_in[gi] != YELLOW) begin
          ycnt_reg <= '0;
        end else if (ycnt_reg != YW'(YELLOW_MIN)) begin
          ycnt_reg <= ycnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  // Prioritised fault classification; lowest code wins, PASS only
  always_comb begin
    detect_code = 3'd0;
    if (state_reg == ST_PASS) begin
      if (|bad_code)                        detect_code = 3'd1;
      else if (&non_red)                    detect_code = 3'd2;
      else if (|bad_step)                   detect_code = 3'd3;
      else if (|short_yellow)               detect_code = 3'd4;
      else if (wd_reg == WW'(WATCHDOG_MAX)) detect_code = 3'd5;
    end
  end

  // Next-state and lamp/flash/watchdog decode
  always_comb begin
    state_next     = state_reg;
    start_cnt_next = start_cnt_reg;
    flash_next     = flash_reg;
    flash_cnt_next = flash_cnt_reg;
    code_next      = code_reg;
    ns_lamp_next   = RED;
    ew_lamp_next   = RED;
    wd_next        = '0;
    case (state_reg)
      ST_STARTUP: begin
        if (start_cnt_reg == SW'(STARTUP_HOLD - 1)) begin
          state_next     = ST_PASS;
          start_cnt_next = '0;
        end else begin
          start_cnt_next = start_cnt_reg + 1'b1;
        end
      end
      ST_PASS: begin
        if (detect_code != 3'd0) begin
          // offending code is replaced by red, flash starts in the red phase
          state_next     = ST_FAULT;
          code_next      = detect_code;
          flash_next     = 1'b1;
          flash_cnt_next = '0;
        end else begin
          ns_lamp_next = ns_light_in;
          ew_lamp_next = ew_light_in;
          if (in_same) begin
            wd_next = (wd_reg == WW'(WATCHDOG_MAX)) ? wd_reg : wd_reg + 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (fault_clear) begin
          state_next     = ST_STARTUP;
          code_next      = 3'd0;
          flash_next     = 1'b0;
          flash_cnt_next = '0;
          start_cnt_next = '0;
        end else begin
          if (flash_cnt_reg == FW'(FLASH_HALF - 1)) begin
            flash_next     = ~flash_reg;
            flash_cnt_next = '0;
          end else begin
            flash_cnt_next = flash_cnt_reg + 1'b1;
          end
          if (!flash_next) begin
            ns_lamp_next = DARK;
            ew_lamp_next = DARK;
          end
        end
      end
      default: state_next = ST_STARTUP;
    endcase
  end

  // State and output registers; prev codes are captured in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_STARTUP;
      start_cnt_reg <= '0;
      flash_cnt_reg <= '0;
      flash_reg     <= 1'b0;
      code_reg      <= 3'd0;
      ns_lamp_reg   <= RED;
      ew_lamp_reg   <= RED;
      prev_ns_reg   <= RED;
      prev_ew_reg   <= RED;
      wd_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      start_cnt_reg <= start_cnt_next;
      flash_cnt_reg <= flash_cnt_next;
      flash_reg     <= flash_next;
      code_reg      <= code_next;
      ns_lamp_reg   <= ns_lamp_next;
      ew_lamp_reg   <= ew_lamp_next;
      prev_ns_reg   <= ns_light_in;
      prev_ew_reg   <= ew_light_in;
      wd_reg        <= wd_next;
    end
  end

`ifdef TRAFFIC_MONITOR_FAULT_COUNT_EN
  logic [7:0] fcount_reg;

  // Count PASS->FAULT entries, saturating; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      fcount_reg <= 8'd0;
    end else if ((detect_code != 3'd0) && (fcount_reg != 8'hFF)) begin
      fcount_reg <= fcount_reg + 8'd1;
    end
  end

  assign fault_count = fcount_reg;
`endif

  assign ns_lamp    = ns_lamp_reg;
  assign ew_lamp    = ew_lamp_reg;
  assign fault      = (state_reg == ST_FAULT);
  assign fault_code = code_reg;
  assign flash      = flash_reg;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor: the stimulus process pushes
// the expected registered outputs for each clock edge; a monitor pops and
// compares one entry shortly after every rising edge.
module tb_traffic_conflict_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] D = 3'b000;

  logic       clk = 1'b0;
  logic       reset;
  logic       fault_clear;
  logic [2:0] ns_in;
  logic [2:0] ew_in;
  logic [2:0] ns_lamp;
  logic [2:0] ew_lamp;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;
`ifdef TRAFFIC_MONITOR_FAULT_COUNT_EN
  logic [7:0] fault_count;
`endif

  traffic_conflict_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .ns_light_in (ns_in),
    .ew_light_in (ew_in),
    .fault_clear (fault_clear),
    .ns_lamp     (ns_lamp),
    .ew_lamp     (ew_lamp),
    .fault       (fault),
    .fault_code  (fault_code),
    .flash       (flash)
`ifdef TRAFFIC_MONITOR_FAULT_COUNT_EN
    ,
    .fault_count (fault_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       f;
    logic [2:0] code;
    logic       fl;
    logic [7:0] fc;
  } exp_t;

  exp_t  expq[$];
  string tagq[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    exp_fc = 0;
  logic  conflict_seen = 1'b0;
  exp_t  mon_e;
  exp_t  mon_got;
  string mon_t;

  // Monitor: one comparison per clock edge, 1 time unit after it
  always @(posedge clk) begin
    #1;
    cyc++;
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      mon_t = tagq.pop_front();
      mon_got.ns   = ns_lamp;
      mon_got.ew   = ew_lamp;
      mon_got.f    = fault;
      mon_got.code = fault_code;
      mon_got.fl   = flash;
`ifdef TRAFFIC_MONITOR_FAULT_COUNT_EN
      mon_got.fc   = fault_count;
`else
      mon_got.fc   = 8'd0;
`endif
      tests++;
      if (mon_got !== mon_e) begin
        fails++;
        $display("FAIL %s cyc=%0d got ns=%b ew=%b fault=%b code=%0d flash=%b cnt=%0d required ns=%b ew=%b fault=%b code=%0d flash=%b cnt=%0d",
                 mon_t, cyc, mon_got.ns, mon_got.ew, mon_got.f, mon_got.code, mon_got.fl, mon_got.fc,
                 mon_e.ns, mon_e.ew, mon_e.f, mon_e.code, mon_e.fl, mon_e.fc);
      end
    end
    if ((ns_lamp != R) && (ns_lamp != D) && (ew_lamp != R) && (ew_lamp != D)) conflict_seen = 1'b1;
  end

  // Drive one cycle of inputs and queue the outputs expected after its edge
  task automatic step(input logic [2:0] ns, input logic [2:0] ew, input logic clr, input logic rst,
                      input logic [2:0] ens, input logic [2:0] eew, input logic ef,
                      input logic [2:0] ecode, input logic efl, input string tag);
    exp_t e;
    ns_in = ns;
    ew_in = ew;
    fault_clear = clr;
    reset = rst;
    e.ns = ens;
    e.ew = eew;
    e.f = ef;
    e.code = ecode;
    e.fl = efl;
`ifdef TRAFFIC_MONITOR_FAULT_COUNT_EN
    e.fc = 8'(exp_fc);
`else
    e.fc = 8'd0;
`endif
    expq.push_back(e);
    tagq.push_back(tag);
    @(negedge clk);
  endtask

  task automatic pass(input logic [2:0] ns, input logic [2:0] ew, input string tag);
    step(ns, ew, 1'b0, 1'b0, ns, ew, 1'b0, 3'd0, 1'b0, tag);
  endtask

  task automatic startup_hold(input logic clr);
    for (int i = 0; i < 4; i++)
      step(R, R, (i == 1) ? clr : 1'b0, 1'b0, R, R, 1'b0, 3'd0, 1'b0, "startup");
  endtask

  task automatic enter_fault(input logic [2:0] ns, input logic [2:0] ew, input logic [2:0] code,
                             input string tag);
    exp_fc++;
    step(ns, ew, 1'b0, 1'b0, R, R, 1'b1, code, 1'b1, tag);
  endtask

  task automatic in_fault(input logic [2:0] ns, input logic [2:0] ew, input logic [2:0] code,
                          input logic fl, input string tag);
    step(ns, ew, 1'b0, 1'b0, fl ? R : D, fl ? R : D, 1'b1, code, fl, tag);
  endtask

  task automatic clear_fault(input logic startup_clr);
    step(R, R, 1'b1, 1'b0, R, R, 1'b0, 3'd0, 1'b0, "fault_clear");
    startup_hold(startup_clr);
  endtask

  // Directed stimulus
  initial begin
    reset = 1'b1;
    fault_clear = 1'b0;
    ns_in = R;
    ew_in = R;
    step(R, R, 1'b0, 1'b1, R, R, 1'b0, 3'd0, 1'b0, "reset");
    startup_hold(1'b0);

    for (int rep = 0; rep < 3; rep++) begin
      repeat (51) pass(G, R, "legal_ns_green");
      repeat (11) pass(Y, R, "legal_ns_yellow");
      repeat (51) pass(R, G, "legal_ew_green");
      repeat (11) pass(R, Y, "legal_ew_yellow");
    end
    pass(R, R, "all_red");

    enter_fault(G, G, 3'd2, "conflict");
    repeat (3) in_fault(G, G, 3'd2, 1'b1, "conflict_hold");
    clear_fault(1'b0);

    repeat (3) pass(G, R, "sy_green");
    repeat (6) pass(Y, R, "sy_yellow6");
    enter_fault(R, R, 3'd4, "short_yellow");
    in_fault(R, R, 3'd4, 1'b1, "short_yellow_hold");
    clear_fault(1'b0);
    repeat (3) pass(G, R, "y10_green");
    repeat (10) pass(Y, R, "y10_yellow");
    pass(R, R, "y10_to_red");
    pass(R, R, "y10_after");

    repeat (2) pass(R, G, "pri_ew_green");
    enter_fault(3'b011, R, 3'd1, "invalid_priority");
    for (int k = 1; k <= 60; k++)
      in_fault(3'b011, R, 3'd1, (k < 25) || (k >= 50), "flash_phase");
    clear_fault(1'b0);

    repeat (201) pass(G, R, "stall_hold");
    enter_fault(G, R, 3'd5, "stall");
    in_fault(G, R, 3'd5, 1'b1, "stall_fault_hold");
    clear_fault(1'b1);
    pass(G, R, "resume");
    step(G, R, 1'b1, 1'b0, G, R, 1'b0, 3'd0, 1'b0, "clear_in_pass");
    pass(G, R, "after_clear_in_pass");
    pass(Y, R, "resume_yellow");

    enter_fault(Y, G, 3'd2, "conflict_pre_reset");
    for (int k = 1; k <= 30; k++)
      in_fault(Y, G, 3'd2, (k < 25), "flash_pre_reset");
    exp_fc = 0;
    step(Y, G, 1'b1, 1'b1, R, R, 1'b0, 3'd0, 1'b0, "reset_mid_fault");
    startup_hold(1'b0);
    pass(G, R, "post_reset_pass");

    @(posedge clk);
    #2;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end
    tests++;
    if (conflict_seen) begin
      fails++;
      $display("FAIL no_conflict_lamps got=1 required=0");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #1000000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
- Safety stage directly downstream of the 4-way light controller. Consumes its ns/ew light codes and drives the physical lamp outputs.
- Passes legal light codes through with one register stage.
- Detects conflicting, malformed, illegally sequenced or stalled light codes, then latches a fault and forces flashing red on both approaches until an explicit clear.

Parameters:
- YELLOW_MIN, 10: minimum consecutive yellow cycles required before yellow->red on either approach.
- STARTUP_HOLD, 4: all-red cycles held after reset or fault clear before pass-through begins.
- FLASH_HALF, 25: cycles per half-period of the fault flash (red on / lamps off).
- WATCHDOG_MAX, 200: maximum cycles the {ns,ew} input pair may stay unchanged before a stall fault.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ns_light_in  in  3  controller NS code: RED=100, YELLOW=010, GREEN=001
- ew_light_in  in  3  controller EW code, same encoding
- fault_clear  in  1  one-cycle request to leave FAULT
- ns_lamp  out  3  registered NS lamp drive
- ew_lamp  out  3  registered EW lamp drive
- fault  out  1  high while in FAULT
- fault_code  out  3  cause of the latched fault; 0 when no fault
- flash  out  1  current flash phase; 1 = red on

Behaviour:
- Clocking/reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=STARTUP; ns_lamp=ew_lamp=100; fault=0; fault_code=0; flash=0; all counters 0; prev_ns=prev_ew=100.
- States:
  - STARTUP: both lamps 100. After STARTUP_HOLD cycles -> PASS.
  - PASS: lamps(n+1) = inputs(n), provided no fault is detected at cycle n.
  - FAULT: lamps flash.
- prev_ns/prev_ew capture the inputs every cycle in all states.
- Fault checks are evaluated combinationally on the inputs versus prev, only in PASS. Lowest code wins:
  - 1 invalid: either input is not exactly one of 100/010/001.
  - 2 conflict: both inputs are non-red in the same cycle.
  - 3 illegal step, on either approach: GREEN->RED, YELLOW->GREEN, or RED->YELLOW.
  - 4 short yellow: YELLOW->RED on an approach whose yellow run counter is < YELLOW_MIN.
  - 5 stall: watchdog count reaches WATCHDOG_MAX.
- Fault detected at cycle n:
  - At n+1: state=FAULT, fault=1, fault_code latched, flash=1, lamps=100/100.
  - The offending code never reaches the lamps.
- FAULT flash:
  - flash toggles every FLASH_HALF cycles.
  - flash=1 -> both lamps 100; flash=0 -> both lamps 000.
  - Further faults are ignored; fault_code holds the first cause.
- fault_clear:
  - Sampled only in FAULT. When high -> next cycle state=STARTUP, fault=0, fault_code=0, flash=0, lamps 100/100, counters cleared.
  - Ignored in STARTUP and PASS.
- Yellow run counters: one per approach. Increment while that input is 010, saturating at YELLOW_MIN. Clear on any non-yellow cycle.
- Watchdog:
  - Counts consecutive cycles with inputs equal to prev; resets on any change.
  - Counts only in PASS; held at 0 in STARTUP and FAULT.
  - Width is $clog2(WATCHDOG_MAX+1).
- Reset asserted in any state, including mid-flash: returns to reset values on the next edge.
- Simultaneous fault_clear and reset: reset wins (same result).

Optional Feature:
- Macro: TRAFFIC_MONITOR_FAULT_COUNT_EN.
- Defined: adds output fault_count[7:0].
  - Increments on every PASS->FAULT entry and saturates at 255.
  - Cleared only by reset, not by fault_clear.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Legal controller sequence (NS green 51 cycles, yellow 11, EW green 51, yellow 11, repeated 3 times) after the 4-cycle startup -> lamps equal the inputs delayed 1 cycle, fault stays 0, ns/ew lamps read 100/100 during cycles 1-4.
- In PASS, drive ns=001 and ew=001 at cycle n -> at n+1 fault=1, fault_code=2, lamps=100/100; lamps never show 001/001.
- NS yellow held 6 cycles then red, with YELLOW_MIN=10 -> fault_code=4; repeat with 10 yellow cycles -> no fault.
- Drive ns=011 simultaneously with a GREEN->RED step on EW -> fault_code=1 (priority); flash toggles 1->0 after 25 cycles and 0->1 after 50; lamps alternate 100/000.
- Hold inputs 001/100 for 200 PASS cycles -> fault_code=5. Pulse fault_clear -> fault=0, 4 all-red cycles, then pass-through resumes. fault_clear pulsed in PASS -> no effect.
- Assert reset mid-FAULT with flash=0 -> next cycle fault=0, lamps 100/100, STARTUP. With TRAFFIC_MONITOR_FAULT_COUNT_EN: 3 faults with clears -> fault_count=3; after reset -> 0.
